// File: rtl/if_id_stage_pkg.sv
// Shared fetch/decode pipeline definitions.
// Constants, fetch FSM states and the IF/ID slot bundle.
package if_id_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP           = 32'd4;

  typedef enum logic {
    RUN,
    HOLD
  } fetch_state_t;

  typedef enum logic [1:0] {
    OP_ADV,
    OP_HOLD,
    OP_FLUSH
  } edge_op_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
  } id_slot_t;

  // Flush beats stall; stall beats advance.
  function automatic edge_op_t edge_op(
    input logic flush,
    input logic stall
  );
    if (flush) return OP_FLUSH;
    if (stall) return OP_HOLD;
    return OP_ADV;
  endfunction

  function automatic logic [XLEN-1:0] align_pc(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_stage_fetch_pc_reg.sv
// Fetch program counter register.
// Holds pc, steps by 4 and takes word-aligned redirects.
module fetch_pc_reg
  import if_id_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  edge_op_t        op;

  assign op = edge_op(flush_i, stall_i);

  always_comb begin
    pc_d = pc_q;
    unique case (op)
      OP_FLUSH: pc_d = align_pc(redirect_pc_i);
      OP_HOLD:  pc_d = pc_q;
      OP_ADV:   pc_d = pc_q + PC_STEP;
      default:  pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register.
// Drives the sync imem, holds IR across stalls, bubbles on redirect.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] ir_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_pc_plus4_o,
  output logic            id_valid_o
);

  logic [XLEN-1:0] pc_q;
  id_slot_t        id_q;
  logic [XLEN-1:0] hold_q;
  fetch_state_t    state_q;
  edge_op_t        op;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_pc_i (redirect_pc_i),
    .pc_o          (pc_q)
  );

  assign op = edge_op(flush_i, stall_i);

  // imem data lives one cycle, so the first stall edge parks it in hold_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q    <= '{valid: 1'b0, pc: '0};
      hold_q  <= NOP_INSTR;
      state_q <= RUN;
    end else begin
      unique case (op)
        OP_FLUSH: begin
          id_q.valid <= 1'b0;
          state_q    <= RUN;
        end
        OP_HOLD: begin
          if (state_q == RUN) begin
            hold_q  <= imem_rdata_i;
            state_q <= HOLD;
          end
        end
        OP_ADV: begin
          id_q    <= '{valid: 1'b1, pc: pc_q};
          state_q <= RUN;
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  assign imem_addr_o   = pc_q;
  assign id_pc_o       = id_q.pc;
  assign id_pc_plus4_o = id_q.pc + PC_STEP;
  assign id_valid_o    = id_q.valid;

  assign ir_o = !id_q.valid       ? NOP_INSTR :
                (state_q == HOLD) ? hold_q    :
                                    imem_rdata_i;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: random stall/flush traffic vs. a slot-level
// model, directed fetch scenarios, and a second DUT near the top of memory.
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [31:0] rpc;
  logic [31:0] rom_xor;

  logic [31:0] addr0, rdata0, ir0, pc0, pc40;
  logic        v0;
  logic [31:0] addr1, rdata1, ir1, pc1, pc41;
  logic        v1;

  always @(posedge clk) rdata0 <= addr0 ^ rom_xor;
  always @(posedge clk) rdata1 <= addr1;

  if_id_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .stall_i       (stall),
    .flush_i       (flush),
    .redirect_pc_i (rpc),
    .imem_addr_o   (addr0),
    .imem_rdata_i  (rdata0),
    .ir_o          (ir0),
    .id_pc_o       (pc0),
    .id_pc_plus4_o (pc40),
    .id_valid_o    (v0)
  );

  if_id_stage #(
    .RESET_PC  (32'hFFFF_FFF8),
    .NOP_INSTR (32'h0000_0013)
  ) dut_hi (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .stall_i       (1'b0),
    .flush_i       (1'b0),
    .redirect_pc_i (32'h0),
    .imem_addr_o   (addr1),
    .imem_rdata_i  (rdata1),
    .ir_o          (ir1),
    .id_pc_o       (pc1),
    .id_pc_plus4_o (pc41),
    .id_valid_o    (v1)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] addr;
    logic        v;
  } exp_t;

  exp_t q[$];

  // Model: a fetch pointer plus one decode slot {valid, pc, instr}.
  logic [31:0] m_fpc;
  logic [31:0] m_ipc;
  logic [31:0] m_iir;
  logic        m_iv;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
               $time);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, " ir"}, ir0, e.ir);
    chk({tag, " id_pc"}, pc0, e.pc);
    chk({tag, " id_pc_plus4"}, pc40, e.pc4);
    chk({tag, " imem_addr"}, addr0, e.addr);
    chk({tag, " id_valid"}, {31'b0, v0}, {31'b0, e.v});
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.v    = m_iv;
    e.ir   = m_iv ? m_iir : NOP;
    e.pc   = m_ipc;
    e.pc4  = m_ipc + 32'd4;
    e.addr = m_fpc;
    return e;
  endfunction

  task automatic model_reset();
    m_fpc = 32'h0;
    m_ipc = 32'h0;
    m_iv  = 1'b0;
    m_iir = NOP;
  endtask

  task automatic cycle(input logic s, input logic f,
                       input logic [31:0] r);
    stall = s;
    flush = f;
    rpc   = r;
    @(posedge clk);
    if (f) begin
      m_fpc = r & ~32'h3;
      m_iv  = 1'b0;
    end else if (!s) begin
      m_iv  = 1'b1;
      m_ipc = m_fpc;
      m_iir = m_fpc ^ rom_xor;
      m_fpc = m_fpc + 32'd4;
    end
    q.push_back(model_out());
    @(negedge clk);
    #1;
  endtask

  // Async reset between edges; outputs must drop without a clock.
  task automatic async_reset(input string tag);
    stall = 1'b0;
    flush = 1'b0;
    rst_n = 1'b0;
    #2;
    model_reset();
    chk_all(tag, model_out());
    rom_xor = $urandom & 32'hFFFF_0000;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) chk_all("mon", q.pop_front());
  end

  initial begin
    logic [31:0] ep[3];
    logic [31:0] ep4[3];
    ep[0]  = 32'hFFFF_FFF8;
    ep[1]  = 32'hFFFF_FFFC;
    ep[2]  = 32'h0000_0000;
    ep4[0] = 32'hFFFF_FFFC;
    ep4[1] = 32'h0000_0000;
    ep4[2] = 32'h0000_0004;
    wait (rst_n === 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("wrap id_pc", pc1, ep[k]);
      chk("wrap plus4", pc41, ep4[k]);
      chk("wrap ir", ir1, ep[k]);
      chk("wrap valid", {31'b0, v1}, 32'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;
    rpc     = 32'h0;
    rom_xor = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk_all("reset", model_out());
    chk("reset plus4", pc40, 32'd4);
    rst_n = 1'b1;

    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    chk("t1 ir", ir0, 32'h8);
    chk("t1 id_pc", pc0, 32'h8);

    repeat (3) begin
      cycle(1'b1, 1'b0, 32'h0);
      chk("t2 hold ir", ir0, 32'h8);
      chk("t2 hold addr", addr0, 32'hC);
    end
    cycle(1'b0, 1'b0, 32'h0);
    chk("t2 release ir", ir0, 32'hC);

    cycle(1'b0, 1'b1, 32'h103);
    chk("t3 bubble ir", ir0, NOP);
    chk("t3 bubble valid", {31'b0, v0}, 32'd0);
    cycle(1'b0, 1'b0, 32'h0);
    chk("t3 target ir", ir0, 32'h100);
    chk("t3 target pc", pc0, 32'h100);

    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h40);
    chk("t4 addr", addr0, 32'h40);
    cycle(1'b0, 1'b0, 32'h0);
    chk("t4 run ir", ir0, 32'h40);

    repeat (2) cycle(1'b1, 1'b0, 32'h0);
    async_reset("t6 async");

    for (int n = 0; n < 500; n++) begin
      logic        s;
      logic        f;
      logic [31:0] r;
      s = ($urandom_range(0, 99) < 30);
      f = ($urandom_range(0, 99) < 12);
      if ($urandom_range(0, 3) == 0)
        r = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else
        r = $urandom & 32'h0000_0FFF;
      if ($urandom_range(0, 149) == 0)
        async_reset("rand async");
      else
        cycle(s, f, r);
    end

    stall = 1'b0;
    flush = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
